// File: rtl/result_collector_pkg.sv
// Shared constants, result-word layout and FSM encodings for the engine result collector.
// Contents:
//   *_DEF      default array size, frame geometry and frame-buffer address width
//   X_W/Y_W/ITR_W  field widths of the engine result word
//   out_word_t result bus payload {x[9:0], y[8:0], itr[7:0]}
//                (x occupies bits 26:17, y bits 16:8, itr bits 7:0)
//   ST_*       collector FSM state encodings
package result_collector_pkg;

  localparam int unsigned NUM_ENGINES_DEF = 16;
  localparam int unsigned H_RES_DEF       = 640;
  localparam int unsigned V_RES_DEF       = 480;
  localparam int unsigned FB_AW_DEF       = 19;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned ITR_W = 8;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ITR_W-1:0] itr;
  } out_word_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/result_collector_if.sv
// Engine result bus plus frame-buffer port A write channel.
// Signals:
//   service_req  engines -> collector, per-engine result-ready level
//   req_ack      collector -> engines, one-hot grant
//   out_word     granted engine -> collector, shared result word
//   fb_addr/fb_data/fb_we  collector -> RAM write request
//   fb_ready     RAM -> collector, accepts write when fb_we && fb_ready
// Modports: master = collector side, slave = engine array / RAM side.
interface result_collector_if
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int unsigned FB_AW       = FB_AW_DEF
) ();

  logic [NUM_ENGINES-1:0] service_req;
  logic [NUM_ENGINES-1:0] req_ack;
  out_word_t              out_word;
  logic [FB_AW-1:0]       fb_addr;
  logic [ITR_W-1:0]       fb_data;
  logic                   fb_we;
  logic                   fb_ready;

  modport master (
    input  service_req, out_word, fb_ready,
    output req_ack, fb_addr, fb_data, fb_we
  );

  modport slave (
    output service_req, out_word, fb_ready,
    input  req_ack, fb_addr, fb_data, fb_we
  );

endinterface

// File: rtl/result_collector_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Ports:
//   req      per-engine request level
//   ptr      search start index
//   grant_c  one-hot grant (zero when no request)
//   idx_c    index of the granted engine
//   valid_c  any request present
module rr_arbiter #(
  parameter int unsigned  NUM_ENGINES = 16,
  localparam int unsigned PW          = $clog2(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [NUM_ENGINES-1:0] grant_c,
  output logic [PW-1:0]          idx_c,
  output logic                   valid_c
);

  // One spare bit so ptr+i can exceed NUM_ENGINES before the wrap subtract.
  logic [PW:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      cand = (PW+1)'(ptr) + (PW+1)'(i);
      if (32'(cand) >= NUM_ENGINES) begin
        cand = cand - (PW+1)'(NUM_ENGINES);
      end
      if (!valid_c && req[cand[PW-1:0]]) begin
        valid_c                = 1'b1;
        idx_c                  = cand[PW-1:0];
        grant_c[cand[PW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_collector.sv
// Round-robin collector for the shared engine result bus: grants one engine,
// captures its {x,y,itr} word, writes itr to the frame buffer at y*H_RES+x,
// and keeps per-frame pixel statistics.
// Ports:
//   Engine_CLK   clock, rising edge
//   eRST_n       async active-low reset
//   bus          result_collector_if.master (engine bus + frame-buffer port A)
//   frame_clear  sync pulse: zero pixel_count, clear frame_done / coord_err
//   pixel_count  writes accepted this frame (saturating)
//   frame_done   sticky, set when pixel_count reaches H_RES*V_RES
//   coord_err    sticky, set on a captured out-of-range coordinate
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF,
  parameter int unsigned FB_AW       = FB_AW_DEF
) (
  input  logic                    Engine_CLK,
  input  logic                    eRST_n,
  result_collector_if.master      bus,
  input  logic                    frame_clear,
  output logic [FB_AW-1:0]        pixel_count,
  output logic                    frame_done,
  output logic                    coord_err
);

  localparam int unsigned     PW        = $clog2(NUM_ENGINES);
  localparam logic [FB_AW-1:0] FRAME_PIX = FB_AW'(H_RES * V_RES);
  localparam logic [FB_AW-1:0] CNT_MAX   = '1;

  logic [2:0]             state_q, state_d;
  logic [NUM_ENGINES-1:0] req_ack_q, req_ack_d;
  logic [PW-1:0]          g_q, g_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   fb_we_q, fb_we_d;
  logic [FB_AW-1:0]       fb_addr_q, fb_addr_d;
  logic [ITR_W-1:0]       fb_data_q, fb_data_d;
  logic [FB_AW-1:0]       cnt_d;
  logic                   done_d, err_d;
  logic                   wr_accept;

  logic [NUM_ENGINES-1:0] arb_grant_c;
  logic [PW-1:0]          arb_idx_c;
  logic                   arb_valid_c;
  logic [FB_AW-1:0]       addr_c;
  logic                   coord_ok_c;

  rr_arbiter #(
    .NUM_ENGINES (NUM_ENGINES)
  ) u_arb (
    .req     (bus.service_req),
    .ptr     (rr_ptr_q),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Linear frame-buffer address and range check of the word on the bus.
  always_comb begin
    addr_c     = FB_AW'(bus.out_word.y) * FB_AW'(H_RES) + FB_AW'(bus.out_word.x);
    coord_ok_c = (32'(bus.out_word.x) < H_RES) && (32'(bus.out_word.y) < V_RES);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    req_ack_d = req_ack_q;
    g_d       = g_q;
    rr_ptr_d  = rr_ptr_q;
    fb_we_d   = fb_we_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    cnt_d     = pixel_count;
    done_d    = frame_done;
    err_d     = coord_err;
    wr_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          req_ack_d = arb_grant_c;
          g_d       = arb_idx_c;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        req_ack_d = '0;
        if (coord_ok_c) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_c;
          fb_data_d = bus.out_word.itr;
          state_d   = ST_WRITE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_WRITE: begin
        if (fb_we_q && bus.fb_ready) begin
          fb_we_d   = 1'b0;
          wr_accept = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Hold off re-arbitration until the served engine has dropped its
        // level request, so a stale request cannot win again.
        if (!bus.service_req[g_q]) begin
          rr_ptr_d = (32'(g_q) == NUM_ENGINES - 1) ? '0 : g_q + PW'(1);
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        req_ack_d = '0;
        fb_we_d   = 1'b0;
      end
    endcase

    if (wr_accept) begin
      if (pixel_count != CNT_MAX) begin
        cnt_d = pixel_count + FB_AW'(1);
      end
      if (cnt_d == FRAME_PIX) begin
        done_d = 1'b1;
      end
    end

    // Clear has priority over a same-cycle increment or error.
    if (frame_clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) begin
      state_q     <= ST_IDLE;
      req_ack_q   <= '0;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
      coord_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ack_q   <= req_ack_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      pixel_count <= cnt_d;
      frame_done  <= done_d;
      coord_err   <= err_d;
    end
  end

  assign bus.req_ack = req_ack_q;
  assign bus.fb_we   = fb_we_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;

endmodule
